// File: rtl/excitatory_column_seq.sv
`default_nettype none
// ============================================================================
// Module   : excitatory_column_seq
// Purpose  : Clocked excitatory column. NEURONS ramp-no-leak neurons
//            integrate binary-weighted synapse ramps over one gamma cycle
//            of PERIOD ticks. Each neuron reports its first threshold
//            crossing as a one-cycle pulse and a spike time.
// Options  : EXC_COLUMN_WTA_EN - when defined, 1-WTA lateral inhibition.
//            The first neuron to fire wins, and ties go to the lowest index.
// Revision : 1.0 - initial release
// ============================================================================
module excitatory_column_seq #(
    parameter int NEURONS   = 12,
    parameter int SYNAPSES  = 32,
    parameter int PERIOD    = 8,
    parameter int WEIGHT_W  = 3,
    parameter int THRESHOLD = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [NEURONS*SYNAPSES-1:0]            in_spikes,
    input  logic [NEURONS*SYNAPSES*WEIGHT_W-1:0]   in_weights,
    output logic                                   busy,
    output logic                                   done,
    output logic [NEURONS-1:0]                     out_spikes,
    output logic [NEURONS*$clog2(PERIOD+1)-1:0]    out_times
);

    localparam int c_WMAX = 2**WEIGHT_W - 1;
    localparam int c_NS   = NEURONS * SYNAPSES;
    localparam int c_PW   = $clog2(SYNAPSES * c_WMAX + 1);
    localparam int c_TW   = $clog2(PERIOD + 1);

    localparam logic [c_PW-1:0]     c_THRESHOLD = c_PW'(THRESHOLD);
    localparam logic [c_TW-1:0]     c_PERIOD_T  = c_TW'(PERIOD);
    localparam logic [c_TW-1:0]     c_LAST_T    = c_TW'(PERIOD - 1);
    localparam logic [c_TW-1:0]     c_ONE_T     = c_TW'(1);
    localparam logic [WEIGHT_W-1:0] c_ONE_W     = WEIGHT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic                           w_accept;
    logic                           w_last;

    logic [c_NS*WEIGHT_W-1:0]       r_weights;
    logic [c_NS*WEIGHT_W-1:0]       r_ramp;
    logic [c_NS*WEIGHT_W-1:0]       w_ramp_next;
    logic [c_NS-1:0]                r_arrived;
    logic [c_NS-1:0]                w_arrived;
    logic [c_NS-1:0]                w_contrib;
    logic [c_PW-1:0]                r_pot      [NEURONS];
    logic [c_PW-1:0]                w_pot_next [NEURONS];
    logic [NEURONS-1:0]             r_fired;
    logic [NEURONS-1:0]             w_cand;
    logic [NEURONS-1:0]             w_fire;
    logic [NEURONS-1:0]             r_spikes;
    logic [NEURONS*c_TW-1:0]        r_times;
    logic [c_TW-1:0]                r_tick;
    logic                           r_done;
`ifdef EXC_COLUMN_WTA_EN
    logic                           w_found;
`endif

    assign busy       = (r_state == S_RUN);
    assign done       = r_done;
    assign out_spikes = r_spikes;
    assign out_times  = r_times;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: start only counts in IDLE; RUN ends after the last tick
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_tick == c_LAST_T) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Synapse ramps and neuron potentials for the current tick
    always_comb begin
        w_arrived   = r_arrived | in_spikes;
        w_contrib   = '0;
        w_ramp_next = r_ramp;
        for (int n = 0; n < NEURONS; n++) begin
            w_pot_next[n] = r_pot[n];
            for (int s = 0; s < SYNAPSES; s++) begin
                // A synapse keeps adding 1 per tick until its ramp reaches its weight
                if (w_arrived[n*SYNAPSES+s] &&
                    (r_ramp[(n*SYNAPSES+s)*WEIGHT_W +: WEIGHT_W] <
                     r_weights[(n*SYNAPSES+s)*WEIGHT_W +: WEIGHT_W])) begin
                    w_contrib[n*SYNAPSES+s] = 1'b1;
                    w_ramp_next[(n*SYNAPSES+s)*WEIGHT_W +: WEIGHT_W] =
                        r_ramp[(n*SYNAPSES+s)*WEIGHT_W +: WEIGHT_W] + c_ONE_W;
                end
                w_pot_next[n] = w_pot_next[n] + c_PW'(w_contrib[n*SYNAPSES+s]);
            end
            w_cand[n] = !r_fired[n] && (w_pot_next[n] >= c_THRESHOLD);
        end
    end

`ifdef EXC_COLUMN_WTA_EN
    // Only the first firing in a gamma survives; lowest index breaks ties
    always_comb begin
        w_fire  = '0;
        w_found = 1'b0;
        if (r_fired == '0) begin
            for (int n = 0; n < NEURONS; n++) begin
                if (w_cand[n] && !w_found) begin
                    w_fire[n] = 1'b1;
                    w_found   = 1'b1;
                end
            end
        end
    end
`else
    // Every neuron fires independently
    always_comb begin
        w_fire = w_cand;
    end
`endif

    // Datapath registers: cleared on accepted start, advanced on each RUN tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_weights <= '0;
            r_ramp    <= '0;
            r_arrived <= '0;
            r_fired   <= '0;
            r_spikes  <= '0;
            r_times   <= {NEURONS{c_PERIOD_T}};
            r_tick    <= '0;
            r_done    <= 1'b0;
            for (int n = 0; n < NEURONS; n++) begin
                r_pot[n] <= '0;
            end
        end else begin
            r_done   <= w_last;
            r_spikes <= '0;
            if (w_accept) begin
                r_weights <= in_weights;
                r_ramp    <= '0;
                r_arrived <= '0;
                r_fired   <= '0;
                r_times   <= {NEURONS{c_PERIOD_T}};
                r_tick    <= '0;
                for (int n = 0; n < NEURONS; n++) begin
                    r_pot[n] <= '0;
                end
            end else if (r_state == S_RUN) begin
                r_ramp    <= w_ramp_next;
                r_arrived <= w_arrived;
                r_fired   <= r_fired | w_fire;
                r_spikes  <= w_fire;
                r_tick    <= r_tick + c_ONE_T;
                for (int n = 0; n < NEURONS; n++) begin
                    r_pot[n] <= w_pot_next[n];
                    if (w_fire[n]) begin
                        r_times[n*c_TW +: c_TW] <= r_tick;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_excitatory_column_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_excitatory_column_seq
// Purpose  : Scoreboard bench for excitatory_column_seq (2 neurons, 4 synapses,
//            3-bit weights, threshold 6, period 8). Stimulus pushes expected
//            output events and a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_excitatory_column_seq;

    localparam int NEURONS   = 2;
    localparam int SYNAPSES  = 4;
    localparam int PERIOD    = 8;
    localparam int WEIGHT_W  = 3;
    localparam int THRESHOLD = 6;

    typedef struct {
        int         cyc;
        logic [1:0] spk;
        logic       dn;
        logic [7:0] tm;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in_spikes;
    logic [23:0] in_weights;
    logic        busy;
    logic        done;
    logic [1:0]  out_spikes;
    logic [7:0]  out_times;

    int   cyc     = 0;
    int   base_c  = 0;
    int   n_checks = 0;
    int   n_pass  = 0;
    ev_t  q[$];
    ev_t  mon_e;
    logic [7:0] spk [PERIOD];

    excitatory_column_seq #(
        .NEURONS   (NEURONS),
        .SYNAPSES  (SYNAPSES),
        .PERIOD    (PERIOD),
        .WEIGHT_W  (WEIGHT_W),
        .THRESHOLD (THRESHOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_spikes  (in_spikes),
        .in_weights (in_weights),
        .busy       (busy),
        .done       (done),
        .out_spikes (out_spikes),
        .out_times  (out_times)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [23:0] mkw(input logic [2:0] a0, a1, a2, a3,
                                        input logic [2:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0, a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic expect_ev(input int off, input logic [1:0] s, input logic d, input logic [7:0] tm);
        ev_t e;
        e.cyc = base_c + off;
        e.spk = s;
        e.dn  = d;
        e.tm  = tm;
        q.push_back(e);
    endtask

    task automatic clr_spk();
        for (int t = 0; t < PERIOD; t++) spk[t] = 8'h00;
    endtask

    // Runs one gamma from the current cycle c and returns in cycle c+9
    task automatic gamma(input logic [23:0] w, input int restart_tick);
        start      = 1'b1;
        in_weights = w;
        in_spikes  = 8'h00;
        @(posedge clk); #1;
        start      = 1'b0;
        in_weights = ~w;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int t = 0; t < PERIOD; t++) begin
            in_spikes = spk[t];
            start     = (t == restart_tick);
            @(posedge clk); #1;
        end
        in_spikes = 8'h00;
        start     = 1'b0;
        chk("busy_in_done_cycle", {31'd0, busy}, 32'd0);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    // Monitor: every output event must match the head of the scoreboard
    always @(negedge clk) begin
        if ((|out_spikes) === 1'b1 || done === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_event: cycle %0d spikes %b done %b times %h, none expected",
                         cyc, out_spikes, done, out_times);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.cyc != cyc || mon_e.spk !== out_spikes ||
                    mon_e.dn !== done || mon_e.tm !== out_times)
                    $display("FAIL event: got cycle %0d spikes %b done %b times %h, expected cycle %0d spikes %b done %b times %h",
                             cyc, out_spikes, done, out_times,
                             mon_e.cyc, mon_e.spk, mon_e.dn, mon_e.tm);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        in_spikes  = 8'h00;
        in_weights = 24'h0;
        clr_spk();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   {31'd0, busy},       32'd0);
        chk("reset_done",   {31'd0, done},       32'd0);
        chk("reset_spikes", {30'd0, out_spikes}, 32'd0);
        chk("reset_times",  {24'd0, out_times},  32'h88);
        rst = 1'b0;
        idle_cycle();

        // Weights 7, spikes on synapses 0,1 at tick 0: potential 2,4,6 -> fire tick 2
        clr_spk(); spk[0] = 8'h03;
        base_c = cyc;
        expect_ev(4, 2'b01, 1'b0, 8'h82);
        expect_ev(9, 2'b00, 1'b1, 8'h82);
        gamma(mkw(7,7,7,7, 0,0,0,0), -1);
        idle_cycle();

        // Weights 1, all four spikes at tick 0: potential plateaus at 4
        clr_spk(); spk[0] = 8'h0F;
        base_c = cyc;
        expect_ev(9, 2'b00, 1'b1, 8'h88);
        gamma(mkw(1,1,1,1, 0,0,0,0), -1);
        idle_cycle();

        // Neuron 0 fires at tick 3, neuron 1 at tick 5
        clr_spk(); spk[1] = 8'h03; spk[3] = 8'h30;
        base_c = cyc;
        expect_ev(5, 2'b01, 1'b0, 8'h83);
`ifdef EXC_COLUMN_WTA_EN
        expect_ev(9, 2'b00, 1'b1, 8'h83);
`else
        expect_ev(7, 2'b10, 1'b0, 8'h53);
        expect_ev(9, 2'b00, 1'b1, 8'h53);
`endif
        gamma(mkw(7,7,0,0, 7,7,0,0), -1);
        idle_cycle();

        // Both neurons fire at tick 3
        clr_spk(); spk[1] = 8'h33;
        base_c = cyc;
`ifdef EXC_COLUMN_WTA_EN
        expect_ev(5, 2'b01, 1'b0, 8'h83);
        expect_ev(9, 2'b00, 1'b1, 8'h83);
`else
        expect_ev(5, 2'b11, 1'b0, 8'h33);
        expect_ev(9, 2'b00, 1'b1, 8'h33);
`endif
        gamma(mkw(7,7,0,0, 7,7,0,0), -1);
        idle_cycle();

        // Repeated spikes: weight-2 synapse adds 2 total, weight-0 synapse nothing
        clr_spk();
        for (int t = 0; t < PERIOD; t++) spk[t] = 8'h11;
        spk[0] = 8'h13;
        base_c = cyc;
        expect_ev(5, 2'b01, 1'b0, 8'h83);
        expect_ev(9, 2'b00, 1'b1, 8'h83);
        gamma(mkw(2,7,0,0, 0,0,0,0), -1);
        idle_cycle();

        // Start pulsed again at c+3 is ignored
        clr_spk(); spk[0] = 8'h03;
        base_c = cyc;
        expect_ev(4, 2'b01, 1'b0, 8'h82);
        expect_ev(9, 2'b00, 1'b1, 8'h82);
        gamma(mkw(7,7,7,7, 0,0,0,0), 2);
        idle_cycle();

        // Start in the done cycle begins a new gamma immediately
        clr_spk(); spk[0] = 8'h03;
        base_c = cyc;
        expect_ev(4, 2'b01, 1'b0, 8'h82);
        expect_ev(9, 2'b00, 1'b1, 8'h82);
        gamma(mkw(7,7,7,7, 0,0,0,0), -1);
        clr_spk(); spk[0] = 8'h0F;
        base_c = cyc;
        expect_ev(9, 2'b00, 1'b1, 8'h88);
        gamma(mkw(1,1,1,1, 0,0,0,0), -1);
        idle_cycle();

        // Reset asserted at c+4 aborts the gamma without a done pulse
        clr_spk(); spk[0] = 8'h03;
        base_c = cyc;
        expect_ev(4, 2'b01, 1'b0, 8'h82);
        start      = 1'b1;
        in_weights = mkw(7,7,7,7, 0,0,0,0);
        idle_cycle();
        start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            in_spikes = spk[t];
            idle_cycle();
        end
        rst       = 1'b1;
        in_spikes = spk[3];
        idle_cycle();
        chk("abort_busy",   {31'd0, busy},       32'd0);
        chk("abort_times",  {24'd0, out_times},  32'h88);
        chk("abort_spikes", {30'd0, out_spikes}, 32'd0);
        chk("abort_done",   {31'd0, done},       32'd0);
        rst       = 1'b0;
        in_spikes = 8'h00;
        repeat (12) idle_cycle();

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/excitatory_column_seq.md
# excitatory_column_seq

Clocked, parametrised successor to the combinational excitatory column. It evaluates NEURONS ramp-no-leak neurons over one gamma cycle of PERIOD clock ticks, using binary multi-bit weights instead of thermometer codes. It reports each neuron's first-spike time and, optionally, applies 1-WTA lateral inhibition. It sits between the ON/OFF receptive-field spike encoder and the STDP weight-update unit.

## Interface
- NEURONS, 12, neurons in the column
- SYNAPSES, 32, synapses per neuron (power of 2)
- PERIOD, 8, ticks per gamma cycle (>=2)
- WEIGHT_W, 3, bits per weight; max weight WMAX = 2^WEIGHT_W-1
- THRESHOLD, 16, firing threshold (1..SYNAPSES*WMAX)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin gamma cycle
- in_spikes  in  NEURONS*SYNAPSES  per-tick spike pulses, one bit per neuron and synapse
- in_weights  in  NEURONS*SYNAPSES*WEIGHT_W  binary weights, sampled on accepted start
- busy  out  1  gamma cycle in progress
- done  out  1  one-cycle pulse: gamma complete, out_times valid
- out_spikes  out  NEURONS  one-cycle pulse per neuron on first threshold crossing
- out_times  out  NEURONS*$clog2(PERIOD+1)  spike tick per neuron; PERIOD = no spike

## Operation
- States: IDLE and RUN.
- IDLE + start: latch in_weights, clear all potentials, arrival flags, ramp counters and fired flags, set every out_times entry to PERIOD, tick counter t=0, go to RUN.
- start while in RUN is ignored.
- RUN, each cycle is tick t:
  - in_spikes bits set the synapse's sticky arrival flag. A flag set on tick t contributes on tick t.
  - A synapse contributes +1 on a tick when its arrival flag is set and its ramp counter is below its weight. The ramp counter then increments.
  - Each neuron's potential increases by the popcount of its contributing synapses.
  - Repeated spikes on an arrived synapse have no effect. A weight of 0 never contributes.
- Potential width is $clog2(SYNAPSES*WMAX+1). No saturation is needed, and overflow is impossible.
- A neuron fires on tick t when it has not fired yet and its new potential is >= THRESHOLD. Firing sets its fired flag and stores out_times[i]=t.
- Neurons keep integrating after firing, but fire at most once per gamma.
- Leaving RUN:
  - After tick PERIOD-1, go to IDLE.
  - At most one firing per neuron per gamma.

## Timing
- Reset values: busy=0, done=0, out_spikes=0, out_times all PERIOD, state IDLE.
- start accepted at cycle c:
  - busy=1 from c+1.
  - Ticks t=0..PERIOD-1 occupy cycles c+1..c+PERIOD.
- Firing on tick t: out_spikes[i] is high for exactly cycle c+t+2, and out_times[i] is updated in that same cycle.
- done is high for exactly cycle c+PERIOD+1, and busy falls in that cycle. If a neuron fires on the last tick, its out_spikes pulse coincides with done.
- out_times holds its values until the next accepted start.
- start in the done cycle is accepted, since the block is IDLE there.
- rst mid-gamma returns the block to reset values on the next edge, with no done pulse.
- in_weights changes during RUN have no effect.

## Configuration
- EXC_COLUMN_WTA_EN defined:
  - 1-WTA. Only the first neuron to fire in a gamma is reported.
  - On a tie in the same tick, the lowest index wins.
  - All other neurons are inhibited: no out_spikes pulse, out_times stays PERIOD.
- EXC_COLUMN_WTA_EN undefined: every neuron fires independently.

## Test plan
Common setup for all scenarios: SYNAPSES=4, WEIGHT_W=3, THRESHOLD=6, PERIOD=8.
- Single neuron, weights {7,7,7,7}, spikes on synapses 0 and 1 at tick 0 -> potential 2,4,6 -> out_times=2, out_spikes pulses at cycle c+4, done at c+9.
- Weights {1,1,1,1}, all four spikes at tick 0 -> potential plateaus at 4 -> no out_spikes pulse, out_times=8, done at c+9.
- Neuron 0 fires at tick 3, neuron 1 at tick 5:
  - WTA off -> out_times {3,5}.
  - WTA on -> {3,8}, single pulse.
  - With both firing at tick 3 and WTA on -> neuron 0 wins.
- Repeated spikes on the same synapse on every tick with weight 2 -> contributes exactly 2 in total.
- start pulsed again at c+3 -> ignored, done still at c+9.
- start pulsed at c+9 -> new gamma, busy stays high from c+10.
- rst asserted at c+4 -> busy=0, out_times all 8, no done pulse.
